// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial addition controller.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bit counter only has to reach WIDTH-1, since terminal count always leaves SHIFT.
    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/serial_bit_adder.sv
// One-bit full adder with its carry flop; carry is loaded from cin when an
// addition is accepted and advanced on every enabled shift cycle.
module serial_bit_adder (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic cin,
    input  logic en,
    input  logic a,
    input  logic b,
    output logic s,
    output logic carry,
    output logic carry_out
);

    logic carry_q;

    assign s         = a ^ b ^ carry_q;
    assign carry_out = (a & b) | (a & carry_q) | (b & carry_q);
    assign carry     = carry_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            carry_q <= 1'b0;
        end else if (load) begin
            carry_q <= cin;
        end else if (en) begin
            carry_q <= carry_out;
        end
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial addition controller: sequences operands LSB-first through
// serial_bit_adder and returns a registered parallel sum. Optional signed
// overflow flag is built when SERIAL_ADD_OVF_EN is defined.
//
// state | meaning
// IDLE  | ready for a new start; abort ignored
// SHIFT | one operand bit per edge; abort returns to IDLE
// DONE  | one-cycle done pulse, then back to IDLE
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic             load, step, last;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic [WIDTH-2:0] sum_sr;
    logic [WIDTH-1:0] sum_full;
    logic [CW-1:0]    cnt;
    logic             bit_s, carry_q, carry_nxt;

    serial_bit_adder u_bit_adder (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .cin       (cin),
        .en        (step),
        .a         (a_sr[0]),
        .b         (b_sr[0]),
        .s         (bit_s),
        .carry     (carry_q),
        .carry_out (carry_nxt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt == LAST) begin
                        last      = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The new sum bit enters at the MSB; after WIDTH shifts this is the full result.
    assign sum_full = {bit_s, sum_sr};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            if (load) begin
                a_sr <= op_a;
                b_sr <= op_b;
                cnt  <= '0;
            end else if (step) begin
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                sum_sr <= sum_full[WIDTH-1:1];
                if (!last) begin
                    cnt <= cnt + CW'(1);
                end
            end
            if (last) begin
                sum  <= sum_full;
                cout <= carry_nxt;
            end
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_q;

    // On the final bit the carry flop holds the carry into the MSB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (last) begin
            ovf_q <= carry_q ^ carry_nxt;
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_carry;
    assign unused_carry = carry_q;
    assign ovf          = 1'b0;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (WIDTH=8): directed and random additions,
// held start, abort and asynchronous reset, checked against an arithmetic model.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         cin = 1'b0;
    logic         ready, busy, done, cout, ovf;
    logic [W-1:0] sum;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    logic [W+1:0] exp_q[$];

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .abort (abort),
        .op_a  (op_a),
        .op_b  (op_b),
        .cin   (cin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // Expected {ovf, cout, sum} from plain integer arithmetic.
    function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic ci);
        int unsigned u;
        int          sg;
        logic        o;
        u  = int'(a) + int'(b) + int'(ci);
        sg = int'($signed(a)) + int'($signed(b)) + int'(ci);
        o  = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
        o = (sg > 127) || (sg < -128);
`endif
        return {o, u[W], u[W-1:0]};
    endfunction

    always @(negedge clk) begin
        if (!reset && done) begin
            logic [W+1:0] e;
            done_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("sum", sum, e[W-1:0]);
                chk("cout", cout, e[W]);
                chk("ovf", ovf, e[W+1]);
            end
        end
    end

    // Issue one addition from IDLE and check the flag timeline around it.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        int n = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 0, 1);
        op_a  = a;
        op_b  = b;
        cin   = ci;
        start = 1'b1;
        @(posedge clk);
        exp_q.push_back(ref_add(a, b, ci));
        #1;
        start = 1'b0;
        op_a  = W'($urandom);
        op_b  = W'($urandom);
        cin   = 1'($urandom);
        for (int j = 0; j < W; j++) begin
            @(negedge clk);
            chk("shift_flags", {ready, busy, done}, 3'b010);
        end
        @(negedge clk);
        chk("done_flags", {ready, busy, done}, 3'b001);
        @(negedge clk);
        chk("idle_flags", {ready, busy, done}, 3'b100);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int rdy_n, busy_n, done_n, d0;
        repeat (2) @(negedge clk);
        chk("rst_flags", {ready, busy, done}, 3'b100);
        chk("rst_sum", sum, 0);
        chk("rst_cout_ovf", {cout, ovf}, 2'b00);
        reset = 1'b0;
        @(negedge clk);

        do_op(8'h0F, 8'h01, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0);
        do_op(8'h7F, 8'h01, 1'b0);
        do_op(8'h00, 8'h00, 1'b1);

        // Start held high: accepts only from IDLE, one op per W+2 cycles.
        d0 = done_cnt;
        rdy_n = 0; busy_n = 0; done_n = 0;
        op_a = 8'h00; op_b = 8'h00; cin = 1'b1;
        repeat (3) exp_q.push_back(ref_add(8'h00, 8'h00, 1'b1));
        start = 1'b1;
        for (int i = 0; i < 3 * (W + 2); i++) begin
            rdy_n  += int'(ready);
            busy_n += int'(busy);
            done_n += int'(done);
            @(negedge clk);
        end
        start = 1'b0;
        chk("held_ready_cycles", rdy_n, 3);
        chk("held_busy_cycles", busy_n, 3 * W);
        chk("held_done_cycles", done_n, 3);
        @(negedge clk);
        chk("held_after_flags", {ready, busy, done}, 3'b100);
        chk("held_done_pulses", done_cnt - d0, 3);

        // Abort on the third SHIFT edge of 0xAA+0x55.
        do_op(8'h12, 8'h34, 1'b0);
        d0 = done_cnt;
        op_a = 8'hAA; op_b = 8'h55; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("abort_flags", {ready, busy, done}, 3'b100);
        repeat (12) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_sum_held", {cout, sum}, 9'h046);

        for (int i = 0; i < 20; i++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            repeat (gap) @(negedge clk);
            do_op(W'($urandom), W'($urandom), 1'($urandom));
        end
        do_op(8'hFF, 8'hFF, 1'b1);

        // Asynchronous reset after bit 3 of 0xF0+0x0F.
        op_a = 8'hF0; op_b = 8'h0F; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_flags", {ready, busy, done}, 3'b100);
        chk("async_rst_sum", sum, 0);
        chk("async_rst_cout_ovf", {cout, ovf}, 2'b00);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        do_op(8'hF0, 8'h0F, 1'b0);

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
